// File: rtl/addr_cha_din_multiplexer_if.sv
// Pin-side bus of the chip driver output mux.
// The driver FSM is the master; the mux is the slave.
interface addr_cha_din_multiplexer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  localparam int SEL_W = $clog2(DATA_W);

  logic [ADDR_W-1:0] sw_cha0_sel;
  logic [ADDR_W-1:0] sw_cha1_sel;
  logic [ADDR_W-1:0] adr_select;
  logic [DATA_W-1:0] reset_val;
  logic [DATA_W-1:0] cha0_data;
  logic [DATA_W-1:0] cha1_data;
  logic [ADDR_W-1:0] cha_select;
  logic [SEL_W-1:0]  din_select;
  logic [ADDR_W-1:0] sel;
  logic [DATA_W-1:0] din_data;
  logic              serial_din;

  modport master (
    output sw_cha0_sel, sw_cha1_sel,
    output adr_select, reset_val,
    output cha0_data, cha1_data,
    output cha_select, din_select,
    input  sel, din_data, serial_din
  );

  modport slave (
    input  sw_cha0_sel, sw_cha1_sel,
    input  adr_select, reset_val,
    input  cha0_data, cha1_data,
    input  cha_select, din_select,
    output sel, din_data, serial_din
  );
endinterface

// File: rtl/addr_cha_din_multiplexer.sv
// Registered address / word / serial-bit selection
// feeding the chip pins directly.
module addr_cha_din_multiplexer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic clk_in,
  input  logic resn,
  addr_cha_din_multiplexer_if.slave bus
);
  localparam int SEL_W = $clog2(DATA_W);
  localparam logic [SEL_W-1:0] MSB_IDX =
    SEL_W'(DATA_W - 1);

  logic [ADDR_W-1:0] sel_d, sel_q;
  logic [DATA_W-1:0] din_data_d, din_data_q;
  logic              serial_din_d, serial_din_q;
  logic [SEL_W-1:0]  bit_idx;

  always_comb begin
    sel_d = '0;
    case (bus.adr_select)
      ADDR_W'(0): sel_d = bus.sw_cha0_sel;
      ADDR_W'(1): sel_d = bus.sw_cha1_sel;
      default:    sel_d = '0;
    endcase
  end

  always_comb begin
    din_data_d = '0;
    case (bus.cha_select)
      ADDR_W'(0): din_data_d = bus.reset_val;
      ADDR_W'(1): din_data_d = bus.cha0_data;
      ADDR_W'(2): din_data_d = bus.cha1_data;
      default:    din_data_d = '0;
    endcase
  end

  // MSB first: index 0 picks the top bit of the live word
  always_comb begin
    bit_idx      = MSB_IDX - bus.din_select;
    serial_din_d = din_data_d[bit_idx];
  end

  always_ff @(posedge clk_in or negedge resn) begin
    if (!resn) begin
      sel_q        <= '0;
      din_data_q   <= '0;
      serial_din_q <= 1'b0;
    end else begin
      sel_q        <= sel_d;
      din_data_q   <= din_data_d;
      serial_din_q <= serial_din_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.din_data   = din_data_q;
  assign bus.serial_din = serial_din_q;
endmodule

// File: tb/tb_addr_cha_din_multiplexer.sv
// Directed bench for addr_cha_din_multiplexer
// with a per-cycle reference model.
module tb_addr_cha_din_multiplexer;
  logic clk_in = 1'b0;
  logic resn   = 1'b0;
  always #5 clk_in = ~clk_in;

  addr_cha_din_multiplexer_if bus ();

  addr_cha_din_multiplexer dut (
    .clk_in (clk_in),
    .resn   (resn),
    .bus    (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;
  bit cmp_en = 1'b0;

  logic [3:0] exp_sel    = '0;
  logic [7:0] exp_data   = '0;
  logic       exp_serial = 1'b0;

  function automatic logic [7:0] m_word(
    input logic [3:0] cs, input logic [7:0] rv,
    input logic [7:0] c0, input logic [7:0] c1);
    logic [7:0] src [3];
    src[0] = rv; src[1] = c0; src[2] = c1;
    return (cs < 4'd3) ? src[cs] : 8'h00;
  endfunction

  function automatic logic [3:0] m_sel(
    input logic [3:0] as, input logic [3:0] s0,
    input logic [3:0] s1);
    if (as == 4'd0) return s0;
    if (as == 4'd1) return s1;
    return 4'h0;
  endfunction

  always @(posedge clk_in or negedge resn) begin
    if (!resn) begin
      exp_sel    <= '0;
      exp_data   <= '0;
      exp_serial <= 1'b0;
    end else begin
      automatic logic [7:0] w = m_word(bus.cha_select,
        bus.reset_val, bus.cha0_data, bus.cha1_data);
      automatic int k = 7 - int'(bus.din_select);
      exp_sel    <= m_sel(bus.adr_select,
        bus.sw_cha0_sel, bus.sw_cha1_sel);
      exp_data   <= w;
      exp_serial <= (w >> k) & 8'h01;
    end
  end

  task automatic check(input string nm,
    input logic [7:0] act, input logic [7:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h",
        nm, act, req);
    end
  endtask

  always @(negedge clk_in) begin
    if (cmp_en) begin
      check("model sel", 8'(bus.sel), 8'(exp_sel));
      check("model din_data", bus.din_data, exp_data);
      check("model serial", 8'(bus.serial_din),
        8'(exp_serial));
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk_all(input string nm,
    input logic [3:0] s, input logic [7:0] d,
    input logic b);
    check({nm, " sel"}, 8'(bus.sel), 8'(s));
    check({nm, " data"}, bus.din_data, d);
    check({nm, " serial"}, 8'(bus.serial_din), 8'(b));
  endtask

  int exp_fe [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
  int exp_a5 [8] = '{1, 0, 1, 0, 0, 1, 0, 1};

  initial begin
    bus.sw_cha0_sel = '0;
    bus.sw_cha1_sel = '0;
    bus.adr_select  = '0;
    bus.reset_val   = '0;
    bus.cha0_data   = '0;
    bus.cha1_data   = '0;
    bus.cha_select  = '0;
    bus.din_select  = '0;
    repeat (2) step();
    chk_all("reset init", 4'h0, 8'h00, 1'b0);
    cmp_en = 1'b1;
    #2 resn = 1'b1;

    bus.sw_cha0_sel = 4'hA;
    bus.sw_cha1_sel = 4'h5;
    bus.adr_select  = 4'd0;
    step(); check("adr 0", 8'(bus.sel), 8'h0A);
    bus.adr_select = 4'd1;
    step(); check("adr 1", 8'(bus.sel), 8'h05);
    bus.adr_select = 4'd7;
    step(); check("adr 7", 8'(bus.sel), 8'h00);
    bus.adr_select = 4'd0;

    bus.reset_val = 8'hFF;
    bus.cha0_data = 8'hFF;
    bus.cha1_data = 8'hFE;
    bus.cha_select = 4'd0;
    step(); check("cha 0", bus.din_data, 8'hFF);
    bus.cha_select = 4'd1;
    step(); check("cha 1", bus.din_data, 8'hFF);
    bus.cha_select = 4'd2;
    step(); check("cha 2", bus.din_data, 8'hFE);
    bus.cha_select = 4'd9;
    step(); check("cha 9", bus.din_data, 8'h00);

    bus.cha_select = 4'd2;
    for (int i = 0; i < 8; i++) begin
      bus.din_select = 3'(i);
      step();
      check($sformatf("ser FE b%0d", i),
        8'(bus.serial_din), 8'(exp_fe[i]));
    end

    bus.cha0_data  = 8'hA5;
    bus.cha_select = 4'd1;
    for (int i = 0; i < 8; i++) begin
      bus.din_select = 3'(i);
      step();
      check($sformatf("ser A5 b%0d", i),
        8'(bus.serial_din), 8'(exp_a5[i]));
    end

    bus.cha1_data  = 8'h7E;
    bus.cha_select = 4'd2;
    bus.din_select = 3'd0;
    #1;
    check("align old data", bus.din_data, 8'hA5);
    check("align old ser", 8'(bus.serial_din), 8'h01);
    step();
    check("align new data", bus.din_data, 8'h7E);
    check("align new ser", 8'(bus.serial_din), 8'h00);

    bus.cha_select = 4'd1;
    bus.din_select = 3'd3;
    step();
    chk_all("pre reset", 4'hA, 8'hA5, 1'b0);
    #2 resn = 1'b0;
    #1 chk_all("async reset", 4'h0, 8'h00, 1'b0);
    repeat (3) step();
    chk_all("reset hold", 4'h0, 8'h00, 1'b0);
    #2 resn = 1'b1;
    bus.din_select = 3'd2;
    #1 chk_all("post release", 4'h0, 8'h00, 1'b0);
    step();
    chk_all("first edge", 4'hA, 8'hA5, 1'b1);

    bus.adr_select  = 4'd1;
    bus.cha_select  = 4'd0;
    bus.reset_val   = 8'h3C;
    bus.din_select  = 3'd5;
    step();
    chk_all("simul change", 4'h5, 8'h3C, 1'b1);
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==",
      n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/addr_cha_din_multiplexer.md
Name: addr_cha_din_multiplexer

Overview:
- Output-side selection block of the chip driver.
- Address path: picks the 4-bit address switch set (sel3..sel0) of the active channel.
- Channel path: picks the 8-bit word to send (reset word, channel 0 data or channel 1 data).
- Serial path: picks one bit of that word for the serial data pin. All outputs are registered on the driver clock and feed the chip pins directly.

Parameters:
- DATA_W, 8: width of channel/reset words; bit-select width is log2(DATA_W) = 3.
- ADDR_W, 4: width of each channel's address switch set and of sel.

Ports:
- clk_in  input  1  driver clock; all state updates on rising edge.
- resn  input  1  asynchronous active-low reset.
- sw_cha0_sel  input  4  channel-0 address switches, bit3..bit0 = sw_cha0_sel3..0.
- sw_cha1_sel  input  4  channel-1 address switches, bit3..bit0 = sw_cha1_sel3..0.
- adr_select  input  4  address source select.
- reset_val  input  8  reset word (driver uses 8'hFF).
- cha0_data  input  8  channel-0 word.
- cha1_data  input  8  channel-1 word.
- cha_select  input  4  word source select.
- din_select  input  3  bit index within selected word.
- sel  output  4  address to chip pins; sel[3]..sel[0] drive sel3..sel0.
- din_data  output  8  selected word (observability).
- serial_din  output  1  selected bit to chip serial input.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (ports clk_in, resn).
- resn low forces, immediately and independent of clk_in: sel=4'h0, din_data=8'h00, serial_din=0.
- Outputs hold these values while resn is low. The first update occurs on the first rising clk_in after resn rises.
- Every output is a single register stage. The value after rising edge N is a function of the inputs sampled at edge N (latency 1 cycle). There are no combinational input-to-output paths.
- Address mux:
  - adr_select==0 -> sel <= sw_cha0_sel.
  - adr_select==1 -> sel <= sw_cha1_sel.
  - adr_select 2..15 -> sel <= 4'h0.
- Channel mux:
  - cha_select==0 -> word = reset_val.
  - cha_select==1 -> word = cha0_data.
  - cha_select==2 -> word = cha1_data.
  - cha_select 3..15 -> word = 8'h00.
  - din_data <= word.
- Serial mux, MSB first:
  - serial_din <= word[7 - din_select]; din_select==0 gives bit 7, din_select==7 gives bit 0.
  - The bit is taken from the same-cycle word (combinational word, not the registered din_data). serial_din and din_data therefore always correspond to the same sample.
- din_select wraps naturally (3-bit); there is no internal counter. Sequencing is owned by the driver FSM.
- Simultaneous changes of any selects and data in one cycle: all take effect together at the next edge; there is no priority between paths.
- Reset asserted mid-word: outputs clear at once. No partial state is retained, because the block holds no state other than the output registers.
- X/unknown selects are not handled specially.

Test Plan:
- Reset: drive resn=0 between clock edges -> sel=0, din_data=0, serial_din=0 with no clock edge; hold 3 cycles -> unchanged.
- Address: sw_cha0_sel=4'hA, sw_cha1_sel=4'h5; adr_select=0 -> sel=4'hA one edge later; adr_select=1 -> sel=4'h5; adr_select=7 -> sel=4'h0.
- Channel:
  - reset_val=8'hFF, cha0_data=8'hFF, cha1_data=8'hFE.
  - cha_select=0/1/2/9 -> din_data=8'hFF/8'hFF/8'hFE/8'h00, each one edge after the change.
- Serialization:
  - cha_select=2, cha1_data=8'hFE, din_select stepped 0..7 each cycle -> serial_din 1,1,1,1,1,1,1,0.
  - With cha0_data=8'hA5, cha_select=1 -> 1,0,1,0,0,1,0,1.
- Latency/alignment: change cha_select 1->2 and din_select 7->0 on the same cycle -> the next edge shows din_data=cha1_data and serial_din=cha1_data[7] together; the previous edge still shows the old values.
- Reset mid-stream: assert resn during din_select=3 of a word -> outputs clear immediately. Release -> the first edge reflects the current inputs.
